// File: rtl/intra_pkg.sv
// ============================================================================
// intra_pkg : shared plane encoding, pixel width and writeback FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package intra_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {
    LUMA = 2'd0,
    CHB  = 2'd1,
    CHR  = 2'd2
  } plane_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_LUMA = 2'd1,
    WR_CHB  = 2'd2,
    WR_CHR  = 2'd3
  } wb_state_e;

  // Luma blocks are 4 rows of one word; chroma blocks are 8 rows of two words.
  function automatic logic [3:0] last_beat(input plane_e p);
    return (p == LUMA) ? 4'd3 : 4'd15;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_addr_gen.sv
// ============================================================================
// wb_addr_gen : maps (plane, block number, beat) to a frame pixel address
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_addr_gen
  import intra_pkg::*;
#(
  parameter int unsigned WIDTH = 1280
) (
  input  plane_e      plane_i,
  input  logic [31:0] mbnumber_i,
  input  logic [3:0]  beat_i,
  output logic [31:0] addr_o
);

  localparam logic [31:0] C_W    = 32'(WIDTH);
  localparam logic [31:0] C_LBPR = 32'(WIDTH / 4);
  localparam logic [31:0] C_CBPR = 32'(WIDTH / 8);

  logic [31:0] bx;
  logic [31:0] by;

  always_comb begin
    bx     = '0;
    by     = '0;
    addr_o = '0;
    if (plane_i == LUMA) begin
      bx     = mbnumber_i % C_LBPR;
      by     = mbnumber_i / C_LBPR;
      addr_o = ((by << 2) + {28'd0, beat_i}) * C_W + (bx << 2);
    end else begin
      // beat = 2*row + half; the right half sits four pixels further on
      bx     = mbnumber_i % C_CBPR;
      by     = mbnumber_i / C_CBPR;
      addr_o = ((by << 3) + {29'd0, beat_i[3:1]}) * C_W + (bx << 3)
             + {29'd0, beat_i[0], 2'b00};
    end
  end

endmodule

`default_nettype wire

// File: rtl/recon_writeback.sv
// ============================================================================
// recon_writeback : buffers reconstructed luma/chroma blocks and streams them
//                   into frame memory one 4-pixel word per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module recon_writeback
  import intra_pkg::*;
#(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned LENGTH = 720
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fb_luma4x4,
  input  logic [15:0][PIX_W-1:0] reconst_luma4x4,
  input  logic                   fb_chromab8x8,
  input  logic [63:0][PIX_W-1:0] reconst_chromab8x8,
  input  logic                   fb_chromar8x8,
  input  logic [63:0][PIX_W-1:0] reconst_chromar8x8,
  output logic [31:0]            mbnumber_luma4x4,
  output logic [31:0]            mbnumber_chromab8x8,
  output logic [31:0]            mbnumber_chromar8x8,
  output logic                   wr_en,
  output logic [1:0]             wr_plane,
  output logic [31:0]            wr_addr,
  output logic [31:0]            wr_data,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam logic [31:0] C_LUMA_LAST   = 32'((WIDTH / 4) * (LENGTH / 4) - 1);
  localparam logic [31:0] C_CHROMA_LAST = 32'((WIDTH / 8) * (LENGTH / 8) - 1);

  wb_state_e              state_q;
  logic [3:0]             beat_q;
  logic [2:0]             pend_q;
  logic [2:0]             wrap_q;
  logic [2:0][31:0]       mb_q;
  logic [15:0][PIX_W-1:0] luma_buf_q;
  logic [63:0][PIX_W-1:0] chb_buf_q;
  logic [63:0][PIX_W-1:0] chr_buf_q;
  logic                   wr_en_q;
  logic [1:0]             wr_plane_q;
  logic [31:0]            wr_addr_q;
  logic [31:0]            wr_data_q;
  logic                   frame_done_q;
  logic                   overflow_q;

  plane_e                 cur_plane;
  plane_e                 sel_plane_d;
  logic [3:0]             sel_beat_d;
  logic                   issue_d;
  logic                   in_wr;
  logic                   fin_beat;
  logic [2:0]             strobe;
  logic [2:0]             fin;
  logic [2:0]             accept;
  logic [2:0]             drop;
  logic [2:0]             wrap_now;
  logic [2:0]             wrap_all;
  logic [31:0]            mb_sel;
  logic [31:0]            addr_d;
  logic [4*PIX_W-1:0]     data_d;

  always_comb begin
    unique case (state_q)
      WR_CHB:  cur_plane = CHB;
      WR_CHR:  cur_plane = CHR;
      default: cur_plane = LUMA;
    endcase
  end

  assign in_wr    = (state_q != IDLE);
  assign fin_beat = in_wr && (beat_q == last_beat(cur_plane));
  assign fin      = fin_beat ? (3'b001 << cur_plane) : 3'b000;

  // A strobe landing on the final beat refills a buffer that is being released.
  assign strobe = {fb_chromar8x8, fb_chromab8x8, fb_luma4x4};
  assign accept = strobe & (~pend_q | fin);
  assign drop   = strobe & ~accept;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      wrap_now[p] = fin[p] && (mb_q[p] == ((p == 0) ? C_LUMA_LAST : C_CHROMA_LAST));
    end
  end
  assign wrap_all = wrap_q | wrap_now;

  // Outputs are registered, so select the beat that will appear next cycle.
  always_comb begin
    sel_plane_d = cur_plane;
    sel_beat_d  = beat_q + 4'd1;
    issue_d     = !fin_beat;
    if (!in_wr) begin
      sel_beat_d = '0;
      issue_d    = |pend_q;
      if (pend_q[0])      sel_plane_d = LUMA;
      else if (pend_q[1]) sel_plane_d = CHB;
      else                sel_plane_d = CHR;
    end
  end

  always_comb begin
    unique case (sel_plane_d)
      CHB:     mb_sel = mb_q[1];
      CHR:     mb_sel = mb_q[2];
      default: mb_sel = mb_q[0];
    endcase
  end

  always_comb begin
    data_d = '0;
    for (int c = 0; c < 4; c++) begin
      unique case (sel_plane_d)
        LUMA:    data_d[PIX_W*c +: PIX_W] = luma_buf_q[{sel_beat_d[1:0], 2'(c)}];
        CHB:     data_d[PIX_W*c +: PIX_W] = chb_buf_q[{sel_beat_d, 2'(c)}];
        default: data_d[PIX_W*c +: PIX_W] = chr_buf_q[{sel_beat_d, 2'(c)}];
      endcase
    end
  end

  wb_addr_gen #(
    .WIDTH (WIDTH)
  ) u_addr_gen (
    .plane_i    (sel_plane_d),
    .mbnumber_i (mb_sel),
    .beat_i     (sel_beat_d),
    .addr_o     (addr_d)
  );

  always_ff @(posedge clk) begin
    if (accept[0]) luma_buf_q <= reconst_luma4x4;
    if (accept[1]) chb_buf_q  <= reconst_chromab8x8;
    if (accept[2]) chr_buf_q  <= reconst_chromar8x8;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      pend_q       <= '0;
      wrap_q       <= '0;
      mb_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_plane_q   <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~fin) | accept;
      if (|drop) overflow_q <= 1'b1;

      for (int p = 0; p < 3; p++) begin
        if (fin[p]) mb_q[p] <= wrap_now[p] ? 32'd0 : mb_q[p] + 32'd1;
      end

      if (&wrap_all) begin
        wrap_q       <= '0;
        frame_done_q <= 1'b1;
      end else begin
        wrap_q       <= wrap_all;
        frame_done_q <= 1'b0;
      end

      if (!in_wr) begin
        if (issue_d) begin
          unique case (sel_plane_d)
            LUMA:    state_q <= WR_LUMA;
            CHB:     state_q <= WR_CHB;
            default: state_q <= WR_CHR;
          endcase
        end
      end else if (fin_beat) begin
        state_q <= IDLE;
      end

      beat_q     <= issue_d ? sel_beat_d : 4'd0;
      wr_en_q    <= issue_d;
      wr_plane_q <= issue_d ? sel_plane_d : 2'd0;
      wr_addr_q  <= issue_d ? addr_d : 32'd0;
      wr_data_q  <= issue_d ? data_d : 32'd0;
    end
  end

  assign mbnumber_luma4x4    = mb_q[0];
  assign mbnumber_chromab8x8 = mb_q[1];
  assign mbnumber_chromar8x8 = mb_q[2];
  assign wr_en               = wr_en_q;
  assign wr_plane            = wr_plane_q;
  assign wr_addr             = wr_addr_q;
  assign wr_data             = wr_data_q;
  assign frame_done          = frame_done_q;
  assign overflow            = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_recon_writeback.sv
// ============================================================================
// tb_recon_writeback : scoreboard bench for recon_writeback (16x8 frame)
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_recon_writeback;

  localparam int W = 16;
  localparam int L = 8;
  localparam int LUMA_BLOCKS = (W / 4) * (L / 4);
  localparam int CH_BLOCKS   = (W / 8) * (L / 8);
  localparam int DRAIN_LIMIT = 400;

  logic             clk = 1'b0;
  logic             reset;
  logic             fb_luma4x4, fb_chromab8x8, fb_chromar8x8;
  logic [15:0][7:0] d_luma;
  logic [63:0][7:0] d_chb, d_chr;
  logic [31:0]      mb_l, mb_b, mb_r;
  logic             wr_en;
  logic [1:0]       wr_plane;
  logic [31:0]      wr_addr, wr_data;
  logic             frame_done, overflow;

  recon_writeback #(.WIDTH(W), .LENGTH(L)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fb_luma4x4          (fb_luma4x4),
    .reconst_luma4x4     (d_luma),
    .fb_chromab8x8       (fb_chromab8x8),
    .reconst_chromab8x8  (d_chb),
    .fb_chromar8x8       (fb_chromar8x8),
    .reconst_chromar8x8  (d_chr),
    .mbnumber_luma4x4    (mb_l),
    .mbnumber_chromab8x8 (mb_b),
    .mbnumber_chromar8x8 (mb_r),
    .wr_en               (wr_en),
    .wr_plane            (wr_plane),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .frame_done          (frame_done),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;
  typedef struct { int cyc; int plane; logic [31:0] addr; } log_t;

  exp_t q0[$], q1[$], q2[$];
  log_t wlog[$];

  int checks = 0, errors = 0;
  int model_mb[3];
  bit model_wrap[3];
  int exp_fd = 0, fd_count = 0, fd_cyc = -1;
  bit fd_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bad(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: frame geometry straight from the addressing rules.
  function automatic logic [31:0] ref_addr(input int p, input int n, input int r, input int half);
    int bs, bpr;
    bs  = (p == 0) ? 4 : 8;
    bpr = W / bs;
    return 32'((bs * (n / bpr) + r) * W + bs * (n % bpr) + 4 * half);
  endfunction

  function automatic logic [7:0] pixel(input int p, input int k);
    if (p == 0) return d_luma[k];
    if (p == 1) return d_chb[k];
    return d_chr[k];
  endfunction

  task automatic push_block(input int p);
    int   bs, nbeats, last;
    exp_t e;
    bs     = (p == 0) ? 4 : 8;
    nbeats = (p == 0) ? 4 : 16;
    last   = (p == 0) ? LUMA_BLOCKS - 1 : CH_BLOCKS - 1;
    for (int b = 0; b < nbeats; b++) begin
      int r, half;
      r      = (p == 0) ? b : b / 2;
      half   = (p == 0) ? 0 : b % 2;
      e.addr = ref_addr(p, model_mb[p], r, half);
      e.data = '0;
      for (int c = 0; c < 4; c++) e.data[8*c +: 8] = pixel(p, r * bs + 4 * half + c);
      if (p == 0) q0.push_back(e);
      else if (p == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    if (model_mb[p] == last) begin
      model_mb[p]   = 0;
      model_wrap[p] = 1'b1;
    end else begin
      model_mb[p]++;
    end
    if (model_wrap[0] && model_wrap[1] && model_wrap[2]) begin
      exp_fd++;
      for (int i = 0; i < 3; i++) model_wrap[i] = 1'b0;
    end
  endtask

  task automatic fill_rand(input logic [2:0] mask);
    for (int k = 0; k < 64; k++) begin
      if (mask[0] && k < 16) d_luma[k] = 8'($urandom);
      if (mask[1]) d_chb[k] = 8'($urandom);
      if (mask[2]) d_chr[k] = 8'($urandom);
    end
  endtask

  // Drive strobes for one cycle; acc marks the blocks the model expects accepted.
  task automatic strobe(input logic [2:0] mask, input logic [2:0] acc);
    for (int p = 0; p < 3; p++) if (acc[p]) push_block(p);
    fb_luma4x4    = mask[0];
    fb_chromab8x8 = mask[1];
    fb_chromar8x8 = mask[2];
    @(posedge clk); #1;
    fb_luma4x4    = 1'b0;
    fb_chromab8x8 = 1'b0;
    fb_chromar8x8 = 1'b0;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < DRAIN_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= DRAIN_LIMIT) bad("drain_timeout", q0.size() + q1.size() + q2.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_mbs(input string tag);
    chk({tag, "_mb_luma"}, mb_l, 32'(model_mb[0]));
    chk({tag, "_mb_chb"},  mb_b, 32'(model_mb[1]));
    chk({tag, "_mb_chr"},  mb_r, 32'(model_mb[2]));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 0);
    chk({tag, "_wr_plane"}, {30'd0, wr_plane}, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 0);
    chk({tag, "_mbs"}, mb_l | mb_b | mb_r, 0);
  endtask

  // Monitor: pops the plane's expected beat whenever the DUT writes.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   have;
    if (reset) begin
      have = 1'b0;
      if (wr_en) begin
        wlog.push_back('{cyc, int'(wr_plane), wr_addr});
        case (wr_plane)
          2'd0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          2'd1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          2'd2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          default: ;
        endcase
        if (!have) begin
          bad("unexpected_write", int'(wr_plane), -1);
        end else begin
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end else begin
        chk("idle_bus_zero", wr_addr | wr_data | {30'd0, wr_plane}, 0);
      end
      if (frame_done) begin
        if (fd_prev) bad("frame_done_width", 2, 1);
        fd_count++;
        fd_cyc = cyc;
      end
      fd_prev = frame_done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, m;
    reset = 1'b0;
    fb_luma4x4 = 1'b0; fb_chromab8x8 = 1'b0; fb_chromar8x8 = 1'b0;
    d_luma = '0; d_chb = '0; d_chr = '0;
    for (int i = 0; i < 3; i++) begin model_mb[i] = 0; model_wrap[i] = 1'b0; end

    // Reset state, with strobes that must be ignored while reset is low
    repeat (2) @(posedge clk); #1;
    fill_rand(3'b111);
    strobe(3'b111, 3'b000);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("no_write_from_reset_strobe", wlog.size(), 0);

    // First luma block, pixel k = k
    for (int k = 0; k < 16; k++) d_luma[k] = 8'(k);
    wlog.delete();
    n0 = cyc;
    strobe(3'b001, 3'b001);
    drain();
    chk("luma_beats", wlog.size(), 4);
    for (int i = 0; i < wlog.size(); i++) chk("luma_cycle", wlog[i].cyc, n0 + 2 + i);
    if (wlog.size() == 4) begin
      chk("luma_addr3", wlog[3].addr, 48);
    end
    chk("mb_luma_after_first", mb_l, 1);

    // Advance to luma block 5
    while (model_mb[0] != 5) begin fill_rand(3'b001); strobe(3'b001, 3'b001); drain(); end
    wlog.delete();
    fill_rand(3'b001);
    strobe(3'b001, 3'b001);
    drain();
    chk("mb5_first_addr", (wlog.size() > 0) ? wlog[0].addr : 32'hFFFF_FFFF, 68);

    // All three planes in one cycle
    fill_rand(3'b111);
    wlog.delete();
    n0 = cyc;
    strobe(3'b111, 3'b111);
    drain();
    chk("all3_beats", wlog.size(), 36);
    for (int i = 0; i < wlog.size() && i < 36; i++) begin
      int ep, ec;
      if (i < 4)       begin ep = 0; ec = n0 + 2 + i;         end
      else if (i < 20) begin ep = 1; ec = n0 + 7 + (i - 4);   end
      else             begin ep = 2; ec = n0 + 24 + (i - 20); end
      chk("all3_plane", wlog[i].plane, ep);
      chk("all3_cycle", wlog[i].cyc, ec);
    end
    chk("all3_overflow", {31'd0, overflow}, 0);
    check_mbs("all3");

    // Randomized plane mixes
    for (int it = 0; it < 24; it++) begin
      logic [2:0] mask;
      mask = 3'($urandom_range(1, 7));
      fill_rand(mask);
      strobe(mask, mask);
      drain();
      check_mbs("rand");
      chk("rand_frame_done_count", fd_count, exp_fd);
      chk("rand_overflow", {31'd0, overflow}, 0);
    end

    // Strobe on the final chb beat is accepted; one during beat 3 is dropped
    fill_rand(3'b010);
    n0 = cyc;
    strobe(3'b010, 3'b010);
    wait_until(n0 + 17);
    fill_rand(3'b010);
    strobe(3'b010, 3'b010);
    chk("final_beat_overflow", {31'd0, overflow}, 0);
    wait_until(n0 + 22);
    fill_rand(3'b010);
    strobe(3'b010, 3'b000);
    chk("beat3_overflow", {31'd0, overflow}, 1);
    drain();
    check_mbs("ovf");

    // Reset during beat 2 of a luma block
    fill_rand(3'b001);
    n0 = cyc;
    strobe(3'b001, 3'b001);
    wait_until(n0 + 4);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    chk("beats_before_reset", q0.size(), 2);
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin model_mb[i] = 0; model_wrap[i] = 1'b0; end
    exp_fd = 0; fd_count = 0; fd_prev = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    wlog.delete();
    repeat (30) begin @(posedge clk); #1; end
    chk("no_write_after_midreset", wlog.size(), 0);

    // One full frame
    for (int i = 0; i < LUMA_BLOCKS; i++) begin fill_rand(3'b001); strobe(3'b001, 3'b001); drain(); end
    for (int i = 0; i < CH_BLOCKS; i++) begin fill_rand(3'b010); strobe(3'b010, 3'b010); drain(); end
    for (int i = 0; i < CH_BLOCKS; i++) begin fill_rand(3'b100); strobe(3'b100, 3'b100); drain(); end
    chk("frame_mbs_zero", mb_l | mb_b | mb_r, 0);
    chk("frame_done_count", fd_count, 1);
    m = (wlog.size() > 0) ? wlog[wlog.size() - 1].cyc : -100;
    chk("frame_done_after_last_write", fd_cyc, m + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/recon_writeback.md
RECON_WRITEBACK -- requirements
Module: recon_writeback

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, frame width in pixels (multiple of 8).
REQ-002 SHALL have parameter LENGTH, default 720, frame height in pixels (multiple of 8).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports: clk (input, 1, rising-edge clock), then reset (input, 1, async active-low reset).
REQ-004 SHALL have the following ports:
- fb_luma4x4, input, 1: one-cycle strobe; reconst_luma4x4 is valid.
- reconst_luma4x4, input, 16x8: 4x4 block; index = row*4 + col.
- fb_chromab8x8, input, 1: strobe for reconst_chromab8x8.
- reconst_chromab8x8, input, 64x8: 8x8 block; index = row*8 + col.
- fb_chromar8x8, input, 1: strobe for reconst_chromar8x8.
- reconst_chromar8x8, input, 64x8: as chromab.
- mbnumber_luma4x4, output, 32: current luma block index.
- mbnumber_chromab8x8, output, 32: current chroma-B block index.
- mbnumber_chromar8x8, output, 32: current chroma-R block index.
- wr_en, output, 1: frame-memory write strobe.
- wr_plane, output, 2: target plane (0 = luma, 1 = chb, 2 = chr).
- wr_addr, output, 32: pixel address of byte lane 0.
- wr_data, output, 32: four pixels; column c is at bits [8c+7:8c].
- frame_done, output, 1: one-cycle frame-complete pulse.
- overflow, output, 1: sticky flag; a strobe arrived while that plane's buffer was still pending.

Function
REQ-005 SHALL capture the block on a strobe at the rising edge into a per-plane holding buffer and set that plane's pending flag.
REQ-006 SHALL run a state machine with states IDLE, WR_LUMA, WR_CHB and WR_CHR.
REQ-007 SHALL, in IDLE, select the highest-priority pending plane (luma > chb > chr) and enter its write state on the next edge; with none pending it SHALL stay in IDLE.
REQ-008 SHALL issue one 4-pixel word per cycle with wr_en high: luma 4 beats (rows 0..3); chroma 16 beats (row r, left half, then row r, right half, for r = 0..7).
REQ-009 SHALL compute luma addresses as: bx = n mod (WIDTH/4); by = n div (WIDTH/4); wr_addr = (4*by + r)*WIDTH + 4*bx.
REQ-010 SHALL compute chroma addresses with /8 and 8* in place of /4 and 4*, plus 4 for the right half.
REQ-011 SHALL, on the final beat of a block: clear that plane's pending flag, increment its mbnumber, and return to IDLE on the next edge.
REQ-012 SHALL wrap mbnumber to 0 after the last block: luma at (WIDTH/4)*(LENGTH/4) - 1; chroma at (WIDTH/8)*(LENGTH/8) - 1.
REQ-013 SHALL set a per-plane wrapped flag at each wrap; when all three are set, SHALL pulse frame_done for one cycle and clear all three flags.
REQ-014 SHALL meet this latency: a strobe in cycle N with the FSM idle gives wr_en high in cycles N+2 onward.
REQ-015 SHALL capture all three planes when their strobes arrive in the same cycle, and write them back to back (luma, chb, chr), with one IDLE cycle between blocks.
REQ-016 SHALL accept, without overflow, a strobe that coincides with that plane's final write beat.
REQ-017 SHALL, on a strobe while that plane's flag is pending with no final beat in progress, drop the strobe, keep the buffer unchanged, and set overflow.
REQ-018 SHALL hold wr_addr, wr_data and wr_plane at 0 whenever wr_en is low.

Reset
REQ-019 SHALL, on reset low (asynchronously, at any point including mid-block), go to IDLE and clear pending flags, wrapped flags, mbnumbers, wr_en, wr_plane, wr_addr, wr_data, frame_done and overflow to 0; a block in flight is discarded.
REQ-020 SHALL ignore strobes while reset is low; the first capture is on the first rising edge after reset deasserts.

Structure
REQ-021 SHALL take the plane encoding (LUMA/CHB/CHR) and pixel width (8) from the shared package intra_pkg.
REQ-022 SHALL contain one sub-module, wb_addr_gen, that maps (plane, mbnumber, beat) to wr_addr combinationally.

Verification (WIDTH=16, LENGTH=8: 8 luma blocks, 2 chroma blocks)
REQ-023 SHALL check: reset, then one fb_luma4x4 carrying pixel k = k -> writes in cycles N+2..N+5 to addresses 0, 16, 32, 48 with data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; mbnumber_luma4x4 = 1.
REQ-024 SHALL check: luma block with mbnumber 5 -> first address 68 (bx = 1, by = 1).
REQ-025 SHALL check: all three strobes in the same cycle -> 4 luma beats, IDLE, 16 chb beats, IDLE, 16 chr beats; overflow stays 0.
REQ-026 SHALL check: second fb_chromab8x8 during beat 3 of chb -> overflow = 1 and chb data unchanged; a strobe on the final beat is accepted with overflow unchanged.
REQ-027 SHALL check: 8 luma blocks and 2 each of chb/chr -> all mbnumbers = 0 and a single frame_done pulse after the last write.
REQ-028 SHALL check: reset asserted during beat 2 of a luma block -> all outputs 0 immediately; no further writes issue after release.
